ifft_mem_reader: RTL and testbench
==================================

Name: ifft_mem_reader

Overview:
- Read-side sequencer for the 28x32 IFFT sample/twiddle memory; the writer side loads the memory, this block drains it.
- On a start pulse it walks all 32 addresses, in natural or bit-reversed order, on the memory's combinational read port.
- It registers each word and presents it on a valid/ready output stream with index and last tags.
- It raises busy so the write-side controller can hold off writes during a drain.

Parameters:
- DATA_W, 28, word width; must match the memory data width.
- ADDR_W, 5, address width; depth is 2**ADDR_W = 32.
- BITREV, 1, 1 = issue addresses in bit-reversed order (IFFT input reordering); 0 = natural order.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a 32-word drain; ignored unless IDLE.
- abort  in  1  cancels a drain in progress.
- raddr  out  ADDR_W  memory read address (combinational read port).
- rdata  in  DATA_W  memory read data; valid the same cycle as raddr.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_W  registered word.
- out_index  out  ADDR_W  sequence count (0..31) of out_data, not the memory address.
- out_last  out  1  high with the word where out_index==31.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, out_valid=0, out_data=0, out_index=0, out_last=0, done=0. Reset mid-drain discards all progress.
- States:
  - IDLE: raddr=0, busy=0. start → RUN, cnt=0.
  - RUN: raddr = BITREV ? bitrev(cnt) : cnt.
  - Capture condition cap = (RUN) && (!out_valid || out_ready).
  - On cap: out_data<=rdata, out_index<=cnt, out_last<=(cnt==31), out_valid<=1, cnt<=cnt+1.
  - If cnt==31 on cap → DRAIN.
  - If out_valid && out_ready && !cap (cannot occur in RUN), out_valid<=0.
  - DRAIN: raddr holds the last address. On out_valid && out_ready: out_valid<=0, out_last<=0, done<=1, → IDLE.
- done: high exactly one cycle, otherwise 0.
- Handshake rules:
  - out_data, out_index and out_last are stable while out_valid && !out_ready.
  - A word is transferred on a cycle where both out_valid and out_ready are high.
  - No bubbles when out_ready stays high.
- Latency and throughput, with start at edge 0 and out_ready=1: words are valid after edges 1..32, last accepted at edge 33, done high for the cycle after edge 33. That is 32 words in 32 cycles.
- Backpressure: with out_ready low, cnt and raddr freeze and the registered word is held; nothing is lost or duplicated.
- start while busy: ignored. start and abort in the same cycle in IDLE: abort wins, block stays IDLE.
- abort in RUN or DRAIN: next edge → IDLE, out_valid<=0, out_last<=0, cnt<=0, done stays 0. Any word not yet accepted is dropped.
- bitrev: 5-bit reversal, e.g. 1→16, 3→24, 6→12, 31→31. Width rule: reverse exactly ADDR_W bits.
- cnt is ADDR_W+1 bits wide internally, or terminates on ==31; no wrap back to 0 inside RUN.
- rdata is sampled only on cap edges; rdata is not assumed stable at other times.

Decomposition:
- Shared package ifft_pkg:
  - constants IFFT_N=32, IFFT_AW=5, IFFT_DW=28;
  - state encoding typedef rd_state_t {IDLE, RUN, DRAIN};
  - function bitrev5.
- One sub-module is natural: ifft_out_reg, the valid/ready output holding register (capture enable, hold-on-stall, clear).
- The FSM, counter and address generation stay in the top module.

Test Plan:
- Memory preloaded with mem[i]=i+0x100, BITREV=1, out_ready=1, start pulse → 32 contiguous beats with out_data sequence 0x100, 0x110, 0x108, 0x118, …, 0x11F. out_index is 0..31, out_last only on beat 31, done one cycle after beat 31, busy high 33 cycles.
- Same preload, BITREV=0 → out_data 0x100..0x11F in order.
- out_ready toggles 1,0,0,1 repeating → each word appears exactly once in order; out_data, out_index and raddr are held during stalls; done follows the last transfer.
- Abort when out_index==10 with out_valid=1, out_ready=0 → next cycle out_valid=0, busy=0, no done. A following start replays from index 0.
- start pulsed again at beat 5 of a drain → ignored; exactly 32 beats and one done.
- rst_n asserted low asynchronously mid-drain (between edges) → out_valid, busy and done go 0 immediately. After release, the block sits in IDLE with raddr=0 until start.

Source files
------------

// File: rtl/ifft_pkg.sv
// Shared definitions for the IFFT sample/twiddle memory read side.
//   IFFT_N  : number of words per drain (memory depth)
//   IFFT_AW : memory address width
//   IFFT_DW : memory data width
//   rd_state_t : reader sequencer states
//   bitrev5 : 5-bit address reversal used for IFFT input reordering
package ifft_pkg;

  localparam int unsigned IFFT_N  = 32;
  localparam int unsigned IFFT_AW = $clog2(IFFT_N);
  localparam int unsigned IFFT_DW = 28;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } rd_state_t;

  function automatic logic [4:0] bitrev5(input logic [4:0] a);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

endpackage

// File: rtl/ifft_out_reg.sv
// Valid/ready output holding register for the IFFT memory reader.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : drop any held word (valid and last cleared)
//   cap          : load a new word from d_* and mark it valid
//   pop          : held word accepted with no new capture; mark invalid
//   d_data/d_index/d_last : word and tags to capture
//   out_valid/out_data/out_index/out_last : registered stream outputs
// With none of clr/cap/pop asserted the word is held unchanged, which
// gives the stall stability the downstream handshake relies on.
module ifft_out_reg #(
  parameter int unsigned DATA_W = 28,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cap,
  input  logic              pop,
  input  logic [DATA_W-1:0] d_data,
  input  logic [ADDR_W-1:0] d_index,
  input  logic              d_last,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (cap) begin
      out_valid <= 1'b1;
      out_data  <= d_data;
      out_index <= d_index;
      out_last  <= d_last;
    end else if (pop) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/ifft_mem_reader.sv
// Read-side sequencer for the IFFT sample/twiddle memory.
// On start it walks every address (natural or bit-reversed order) on the
// memory's combinational read port, registers each word and presents it on
// a valid/ready stream tagged with its sequence index and a last flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a full drain (only honoured in IDLE)
//   abort      : cancel a drain in progress; unaccepted word is dropped
//   raddr      : memory read address
//   rdata      : memory read data, valid in the same cycle as raddr
//   out_valid/out_ready : output stream handshake
//   out_data   : registered memory word
//   out_index  : sequence count of out_data (not the memory address)
//   out_last   : marks the final word of a drain
//   busy       : drain in progress; write side must hold off
//   done       : one-cycle pulse after the final word is accepted
module ifft_mem_reader
  import ifft_pkg::*;
#(
  parameter int unsigned DATA_W = IFFT_DW,
  parameter int unsigned ADDR_W = IFFT_AW,
  parameter bit          BITREV = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  rd_state_t         state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_rev;
  logic              cnt_last;
  logic              cap;
  logic              pop;
  logic              clr;
  logic              xfer;

  // Address reversal over exactly ADDR_W bits.
  if (ADDR_W == 5) begin : g_rev5
    assign cnt_rev = bitrev5(cnt);
  end else begin : g_revn
    always_comb begin
      cnt_rev = '0;
      for (int unsigned i = 0; i < ADDR_W; i++) begin
        cnt_rev[i] = cnt[ADDR_W-1-i];
      end
    end
  end

  assign cnt_last = (cnt == '1);
  assign xfer     = out_valid && out_ready;
  assign cap      = (state == RUN) && (!out_valid || out_ready);
  assign pop      = xfer && !cap;
  assign clr      = abort && (state != IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    raddr = '0;
    if (state != IDLE) begin
      raddr = BITREV ? cnt_rev : cnt;
    end
  end

  // The counter stops at its final value instead of stepping past it, so
  // raddr keeps presenting the last address throughout DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cap) begin
            if (cnt_last) begin
              state <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (xfer) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  ifft_out_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .cap       (cap),
    .pop       (pop),
    .d_data    (rdata),
    .d_index   (cnt),
    .d_last    (cnt_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_ifft_mem_reader.sv
module tb_ifft_mem_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        out_ready;

  logic [4:0]  raddr_r,  raddr_n;
  logic [27:0] rdata_r,  rdata_n;
  logic        valid_r,  valid_n;
  logic [27:0] data_r,   data_n;
  logic [4:0]  index_r,  index_n;
  logic        last_r,   last_n;
  logic        busy_r,   busy_n;
  logic        done_r,   done_n;

  logic [27:0] mem [32];

  // Hand-computed 5-bit reversal of 0..31.
  int unsigned rev_tab [32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                                1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

  int checks;
  int failures;

  assign rdata_r = mem[raddr_r];
  assign rdata_n = mem[raddr_n];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ifft_mem_reader #(.DATA_W(28), .ADDR_W(5), .BITREV(1'b1)) u_rev (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .raddr(raddr_r), .rdata(rdata_r), .out_valid(valid_r), .out_ready(out_ready),
    .out_data(data_r), .out_index(index_r), .out_last(last_r),
    .busy(busy_r), .done(done_r)
  );

  ifft_mem_reader #(.DATA_W(28), .ADDR_W(5), .BITREV(1'b0)) u_nat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .raddr(raddr_n), .rdata(rdata_n), .out_valid(valid_n), .out_ready(out_ready),
    .out_data(data_n), .out_index(index_n), .out_last(last_n),
    .busy(busy_n), .done(done_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lets any drain in progress run out with ready high, bounded.
  task automatic settle();
    out_ready = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy_r && !busy_n) break;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    #12;
    checks++;
    if ({valid_r, busy_r, done_r, last_r} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {valid_r, busy_r, done_r, last_r});
    end
    checks++;
    if (data_r !== 28'h0 || index_r !== 5'd0 || raddr_r !== 5'd0) begin
      failures++;
      $display("FAIL reset_regs data=%h index=%0d raddr=%0d want 0/0/0", data_r, index_r, raddr_r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (busy_r !== 1'b0 || raddr_r !== 5'd0 || valid_r !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b raddr=%0d valid=%b want 0/0/0", busy_r, raddr_r, valid_r);
    end
  endtask

  // ready held high: 32 contiguous beats in both orders, done after beat 31.
  task automatic test_stream();
    int busy_cycles;
    int bad;
    busy_cycles = 0;
    bad = 0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (busy_r) busy_cycles++;
    checks++;
    if (valid_r !== 1'b0 || busy_r !== 1'b1 || raddr_r !== 5'd0) begin
      failures++;
      $display("FAIL stream_first_cycle valid=%b busy=%b raddr=%0d want 0/1/0", valid_r, busy_r, raddr_r);
    end
    for (int k = 0; k < 32; k++) begin
      tick();
      if (busy_r) busy_cycles++;
      checks++;
      if (valid_r !== 1'b1 || index_r !== 5'(k) || data_r !== 28'(32'h100 + rev_tab[k])
          || last_r !== (k == 31) || done_r !== 1'b0) begin
        failures++;
        bad++;
        $display("FAIL rev_beat%0d valid=%b idx=%0d data=%h last=%b want 1/%0d/%h/%b",
                 k, valid_r, index_r, data_r, last_r, k, 32'h100 + rev_tab[k], k == 31);
      end
      checks++;
      if (valid_n !== 1'b1 || index_n !== 5'(k) || data_n !== 28'(32'h100 + k) || last_n !== (k == 31)) begin
        failures++;
        $display("FAIL nat_beat%0d valid=%b idx=%0d data=%h last=%b want 1/%0d/%h/%b",
                 k, valid_n, index_n, data_n, last_n, k, 32'h100 + k, k == 31);
      end
    end
    checks++;
    if (raddr_r !== 5'd31 || raddr_n !== 5'd31) begin
      failures++;
      $display("FAIL drain_raddr got=%0d/%0d want 31/31", raddr_r, raddr_n);
    end
    tick();
    if (busy_r) busy_cycles++;
    checks++;
    if (done_r !== 1'b1 || done_n !== 1'b1 || valid_r !== 1'b0 || last_r !== 1'b0 || busy_r !== 1'b0) begin
      failures++;
      $display("FAIL stream_done done=%b/%b valid=%b last=%b busy=%b want 1/1/0/0/0",
               done_r, done_n, valid_r, last_r, busy_r);
    end
    checks++;
    if (busy_cycles != 33) begin
      failures++;
      $display("FAIL busy_cycles got=%0d want 33", busy_cycles);
    end
    tick();
    checks++;
    if (done_r !== 1'b0 || raddr_r !== 5'd0) begin
      failures++;
      $display("FAIL done_width done=%b raddr=%0d want 0/0", done_r, raddr_r);
    end
  endtask

  // ready pattern 1,0,0,1: each word once, in order, held while stalled.
  task automatic test_backpressure();
    logic        p_valid, p_ready;
    logic [27:0] p_data;
    logic [4:0]  p_index, p_raddr;
    int          next_idx, done_cnt, done_c, last_c, dup_bad, hold_bad;
    logic [3:0]  pat;
    pat = 4'b1001;
    next_idx = 0; done_cnt = 0; done_c = -1; last_c = -2; dup_bad = 0; hold_bad = 0;
    p_valid = 1'b0; p_ready = 1'b1; p_data = '0; p_index = '0; p_raddr = '0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (done_r) begin
        done_cnt++;
        done_c = c;
      end
      if (p_valid && !p_ready && hold_bad == 0) begin
        checks++;
        if (data_r !== p_data || index_r !== p_index || raddr_r !== p_raddr || valid_r !== 1'b1) begin
          failures++;
          hold_bad++;
          $display("FAIL stall_hold c=%0d data=%h idx=%0d raddr=%0d want %h/%0d/%0d",
                   c, data_r, index_r, raddr_r, p_data, p_index, p_raddr);
        end
      end
      out_ready = pat[c % 4];
      if (valid_r && out_ready) begin
        if (dup_bad == 0) begin
          checks++;
          if (index_r !== 5'(next_idx) || data_r !== 28'(32'h100 + rev_tab[next_idx % 32])
              || last_r !== (next_idx == 31)) begin
            failures++;
            dup_bad++;
            $display("FAIL bp_xfer%0d idx=%0d data=%h last=%b want %0d/%h/%b", next_idx,
                     index_r, data_r, last_r, next_idx, 32'h100 + rev_tab[next_idx % 32], next_idx == 31);
          end
        end
        if (next_idx == 31) last_c = c;
        next_idx++;
      end
      p_valid = valid_r; p_ready = out_ready; p_data = data_r;
      p_index = index_r; p_raddr = raddr_r;
      if (done_cnt > 0 && c > done_c + 2) break;
      tick();
    end
    checks++;
    if (next_idx != 32 || done_cnt != 1 || done_c != last_c + 1) begin
      failures++;
      $display("FAIL bp_summary xfers=%0d dones=%0d done_c=%0d last_c=%0d want 32/1/last+1",
               next_idx, done_cnt, done_c, last_c);
    end
    settle();
  endtask

  // Abort with word 10 stalled, then a fresh start replays from index 0.
  task automatic test_abort();
    int found;
    found = 0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid_r && index_r == 5'd10) begin
        found = 1;
        break;
      end
      tick();
    end
    checks++;
    if (found != 1) begin
      failures++;
      $display("FAIL abort_reach_idx10 found=%0d want 1", found);
    end
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (valid_r !== 1'b0 || busy_r !== 1'b0 || done_r !== 1'b0 || last_r !== 1'b0) begin
      failures++;
      $display("FAIL abort_effect valid=%b busy=%b done=%b last=%b want 0/0/0/0", valid_r, busy_r, done_r, last_r);
    end
    tick();
    checks++;
    if (done_r !== 1'b0 || busy_r !== 1'b0 || raddr_r !== 5'd0) begin
      failures++;
      $display("FAIL abort_no_done done=%b busy=%b raddr=%0d want 0/0/0", done_r, busy_r, raddr_r);
    end
    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy_r !== 1'b0) begin
      failures++;
      $display("FAIL start_abort_idle busy=%b want 0", busy_r);
    end
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (valid_r !== 1'b1 || index_r !== 5'd0 || data_r !== 28'h100) begin
      failures++;
      $display("FAIL abort_replay valid=%b idx=%0d data=%h want 1/0/100", valid_r, index_r, data_r);
    end
    settle();
  endtask

  // start pulsed at beat 5 of a drain is ignored.
  task automatic test_start_while_busy();
    int beats, dones, order_bad;
    beats = 0; dones = 0; order_bad = 0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      start = 1'b0;
      if (done_r) dones++;
      if (valid_r) begin
        if (index_r !== 5'(beats)) order_bad++;
        if (beats == 5) start = 1'b1;
        beats++;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (beats != 32 || dones != 1 || order_bad != 0) begin
      failures++;
      $display("FAIL start_busy beats=%0d dones=%0d order_errs=%0d want 32/1/0", beats, dones, order_bad);
    end
  endtask

  // Asynchronous reset between edges mid-drain.
  task automatic test_async_reset();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_r !== 1'b0 || busy_r !== 1'b0 || done_r !== 1'b0 || index_r !== 5'd0) begin
      failures++;
      $display("FAIL async_reset valid=%b busy=%b done=%b idx=%0d want 0/0/0/0", valid_r, busy_r, done_r, index_r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy_r !== 1'b0 || raddr_r !== 5'd0 || valid_r !== 1'b0 || done_r !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle busy=%b raddr=%0d valid=%b done=%b want 0/0/0/0",
               busy_r, raddr_r, valid_r, done_r);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) mem[i] = 28'(32'h100 + i);
    test_reset();
    test_stream();
    test_backpressure();
    test_abort();
    test_start_while_busy();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
